// File: rtl/speed_ramp.sv
// Acceleration-limited setpoint generator feeding the speed PID.
// Each wheel channel slews toward its target by one bounded step per ramp tick.
module speed_ramp #(
   parameter int CLK_FREQ  = 1000,
   parameter int RAMP_FREQ = 100,
   parameter int PID_RES   = 16,
   parameter int ACC_RES   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      en,
   input  logic signed [PID_RES-1:0] targetL_i,
   input  logic signed [PID_RES-1:0] targetR_i,
   input  logic        [ACC_RES-1:0] acc_i,
   input  logic        [ACC_RES-1:0] dec_i,
   input  logic                      stop_i,
   input  logic        [ACC_RES-1:0] estop_dec_i,
   output logic signed [PID_RES-1:0] speedL_o,
   output logic signed [PID_RES-1:0] speedR_o,
   output logic                      tick_o,
   output logic                      busy_o
);
   localparam int N  = CLK_FREQ / RAMP_FREQ;
   localparam int CW = $clog2(N);
   localparam int WE = PID_RES + 1;

   logic [CW-1:0]             cnt_reg;
   logic                      tick_int;
   logic                      tick_reg;
   logic                      busy_reg;
   logic signed [PID_RES-1:0] cur_reg  [2];
   logic signed [PID_RES-1:0] tgt      [2];
   logic signed [PID_RES-1:0] next_val [2];
   logic        [1:0]         mismatch;

   assign tick_int = en && (cnt_reg == CW'(N - 1));
   assign tgt[0]   = targetL_i;
   assign tgt[1]   = targetR_i;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic signed [PID_RES-1:0] t;
         logic signed [PID_RES-1:0] cur;
         logic signed [WE-1:0]      cur_x;
         logic signed [WE-1:0]      err;
         logic        [WE-1:0]      abs_err;
         logic        [WE-1:0]      abs_cur;
         logic        [WE-1:0]      step_x;
         logic        [ACC_RES-1:0] s;
         logic                      increase;

         always_comb begin
            t        = stop_i ? '0 : tgt[gi];
            cur      = cur_reg[gi];
            // Widened arithmetic so |err| and |cur| never wrap at the extremes.
            cur_x    = {cur[PID_RES-1], cur};
            err      = {t[PID_RES-1], t} - cur_x;
            abs_err  = err[WE-1] ? -err : err;
            abs_cur  = cur_x[WE-1] ? -cur_x : cur_x;
            increase = (cur == '0) || (err[WE-1] == cur[PID_RES-1]);
            s        = stop_i ? estop_dec_i : (increase ? acc_i : dec_i);
            step_x   = WE'(s);
            if (abs_err <= step_x) begin
               next_val[gi] = t;
            end else if (!increase && (t != '0) && (t[PID_RES-1] != cur[PID_RES-1])
                         && (abs_cur <= step_x)) begin
               // Stop at zero before crossing; the next tick accelerates away.
               next_val[gi] = '0;
            end else if (err[WE-1]) begin
               // Modular add is exact here: the result lies between cur and t.
               next_val[gi] = cur - step_x[PID_RES-1:0];
            end else begin
               next_val[gi] = cur + step_x[PID_RES-1:0];
            end
            mismatch[gi] = (next_val[gi] != t);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg    <= '0;
         cur_reg[0] <= '0;
         cur_reg[1] <= '0;
         tick_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         if (en) begin
            cnt_reg <= (cnt_reg == CW'(N - 1)) ? '0 : cnt_reg + 1'b1;
         end
         tick_reg <= tick_int;
         if (tick_int) begin
            cur_reg[0] <= next_val[0];
            cur_reg[1] <= next_val[1];
            busy_reg   <= |mismatch;
         end
      end
   end

   assign speedL_o = cur_reg[0];
   assign speedR_o = cur_reg[1];
   assign tick_o   = tick_reg;
   assign busy_o   = busy_reg;
endmodule
